// File: rtl/rx_data_sampler.sv
// UART receiver oversampling front stage: counts oversample edges and bit periods, and
// produces one 2-of-3 majority-voted bit per bit period as a single-cycle valid pulse.
module rx_data_sampler #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  asy_reset,
    input  logic                  sampler_enable,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_data,
    output logic                  sampled_data_valid,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic                  prescale_err
);

    logic                  legal;
    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] mid_m1;
    logic [PRESCALE_W-1:0] mid_p1;
    logic                  majority;

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic                  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    // Illegal ratios fall back to 8 so the counters always have a sane wrap point.
    always_comb begin
        legal = (prescale == PRESCALE_W'(8)) || (prescale == PRESCALE_W'(16)) ||
                (prescale == PRESCALE_W'(32));
        p_eff     = legal ? prescale : PRESCALE_W'(8);
        last_edge = p_eff - PRESCALE_W'(1);
        mid       = p_eff >> 1;
        mid_m1    = mid - PRESCALE_W'(1);
        mid_p1    = mid + PRESCALE_W'(1);
        majority  = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
    end

    always_comb begin
        edge_d  = edge_q;
        bit_d   = bit_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = ~legal;
        if (!sampler_enable) begin
            edge_d = '0;
            bit_d  = '0;
            s0_d   = 1'b0;
            s1_d   = 1'b0;
        end else begin
            if (edge_q == last_edge) begin
                edge_d = '0;
                if (bit_q != {BIT_CNT_W{1'b1}}) begin
                    bit_d = bit_q + BIT_CNT_W'(1);
                end
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
            end
            if (edge_q == mid_m1) begin
                s0_d = rx_in;
            end
            if (edge_q == mid) begin
                s1_d = rx_in;
            end
            if (edge_q == mid_p1) begin
                data_d  = majority;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_based_on_prescale) begin
        if (!asy_reset) begin
            edge_q  <= '0;
            bit_q   <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign sampled_data       = data_q;
    assign sampled_data_valid = valid_q;
    assign edge_count         = edge_q;
    assign bit_count          = bit_q;
    assign prescale_err       = err_q;

endmodule

// File: tb/tb_rx_data_sampler.sv
// Directed bench for rx_data_sampler; inputs change and outputs are checked 1 time unit after
// each rising edge, so "cycle k" is the k-th cycle after enable was raised.
module tb_rx_data_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rx;
    logic [5:0] prescale;
    logic       sdata;
    logic       svalid;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       perr;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] pat = 11'b11010011010;

    rx_data_sampler #(
        .PRESCALE_W(6),
        .BIT_CNT_W (4)
    ) dut (
        .clk_based_on_prescale(clk),
        .asy_reset            (rst_n),
        .sampler_enable       (en),
        .rx_in                (rx),
        .prescale             (prescale),
        .sampled_data         (sdata),
        .sampled_data_valid   (svalid),
        .edge_count           (edge_cnt),
        .bit_count            (bit_cnt),
        .prescale_err         (perr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        rx       = 1'b1;
        prescale = 6'd8;
        tick(2);
        chk("rst_edge", edge_cnt, 0);
        chk("rst_bit", bit_cnt, 0);
        chk("rst_data", sdata, 0);
        chk("rst_valid", svalid, 0);
        chk("rst_err", perr, 0);
        rst_n = 1'b1;

        // P=8, constant high line
        en = 1'b1;
        chk("t1_edge0", edge_cnt, 0);
        chk("t1_bit0", bit_cnt, 0);
        for (int c = 1; c <= 23; c++) begin
            tick(1);
            chk("t1_edge", edge_cnt, c % 8);
            chk("t1_bit", bit_cnt, c / 8);
            chk("t1_valid", svalid, (c == 6 || c == 14 || c == 22) ? 1 : 0);
            if (c == 6 || c == 14 || c == 22) chk("t1_data", sdata, 1);
        end
        en = 1'b0;
        tick(1);
        chk("t1_off_edge", edge_cnt, 0);
        chk("t1_off_bit", bit_cnt, 0);
        chk("t1_off_data", sdata, 1);

        // P=16, glitch outvoted in bit 0, two lows win in bit 1
        prescale = 6'd16;
        en       = 1'b1;
        for (int c = 0; c < 28; c++) begin
            rx = (c == 8 || c == 23 || c == 25) ? 1'b0 : 1'b1;
            tick(1);
            chk("t2_valid", svalid, (c + 1 == 10 || c + 1 == 26) ? 1 : 0);
            if (c + 1 == 10) chk("t2_data_b0", sdata, 1);
            if (c + 1 == 26) chk("t2_data_b1", sdata, 0);
        end
        en = 1'b0;
        rx = 1'b1;
        tick(1);

        // P=32, full frame then bit_count saturation
        prescale = 6'd32;
        en       = 1'b1;
        for (int b = 0; b < 11; b++) begin
            for (int e = 0; e < 32; e++) begin
                rx = pat[b];
                tick(1);
                if (e + 1 == 18) begin
                    chk("t3_valid", svalid, 1);
                    chk("t3_data", sdata, pat[b]);
                end
                if (e + 1 == 19) chk("t3_valid_off", svalid, 0);
            end
        end
        rx = 1'b1;
        chk("t3_bit11", bit_cnt, 11);
        chk("t3_edge_wrap", edge_cnt, 0);
        tick(160);
        chk("t3_bit_sat", bit_cnt, 15);
        tick(32);
        chk("t3_bit_hold", bit_cnt, 15);
        en = 1'b0;
        tick(1);

        // P=8, enable dropped mid-bit
        prescale = 6'd8;
        rx       = 1'b0;
        en       = 1'b1;
        tick(14);
        chk("t4_valid_b1", svalid, 1);
        chk("t4_data_b1", sdata, 0);
        tick(6);
        chk("t4_edge4", edge_cnt, 4);
        chk("t4_bit2", bit_cnt, 2);
        en = 1'b0;
        rx = 1'b1;
        tick(1);
        chk("t4_drop_edge", edge_cnt, 0);
        chk("t4_drop_bit", bit_cnt, 0);
        chk("t4_drop_valid", svalid, 0);
        chk("t4_drop_data", sdata, 0);
        tick(2);
        chk("t4_idle_valid", svalid, 0);
        en = 1'b1;
        tick(5);
        chk("t4_re_novalid", svalid, 0);
        tick(1);
        chk("t4_re_valid", svalid, 1);
        chk("t4_re_data", sdata, 1);
        en = 1'b0;
        tick(1);

        // Enable dropped on the mid+1 edge: no pulse, data kept
        rx = 1'b0;
        en = 1'b1;
        tick(5);
        chk("t4b_edge5", edge_cnt, 5);
        en = 1'b0;
        tick(1);
        chk("t4b_valid", svalid, 0);
        chk("t4b_data", sdata, 1);

        // Illegal prescale falls back to 8
        prescale = 6'd12;
        chk("t5_err_pre", perr, 0);
        tick(1);
        chk("t5_err", perr, 1);
        en = 1'b1;
        tick(6);
        chk("t5_valid", svalid, 1);
        chk("t5_data", sdata, 0);
        chk("t5_edge6", edge_cnt, 6);
        tick(2);
        chk("t5_wrap_edge", edge_cnt, 0);
        chk("t5_wrap_bit", bit_cnt, 1);
        en       = 1'b0;
        prescale = 6'd16;
        tick(1);
        chk("t5_err_clr", perr, 0);

        // Reset mid-frame, then restart with enable held
        rx = 1'b1;
        en = 1'b1;
        tick(53);
        chk("t6_edge5", edge_cnt, 5);
        chk("t6_bit3", bit_cnt, 3);
        chk("t6_data_pre", sdata, 1);
        rst_n = 1'b0;
        tick(1);
        chk("t6_rst_edge", edge_cnt, 0);
        chk("t6_rst_bit", bit_cnt, 0);
        chk("t6_rst_data", sdata, 0);
        chk("t6_rst_valid", svalid, 0);
        rst_n = 1'b1;
        tick(1);
        chk("t6_restart_edge", edge_cnt, 1);
        chk("t6_restart_bit", bit_cnt, 0);
        tick(9);
        chk("t6_valid", svalid, 1);
        chk("t6_data", sdata, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
